// File: rtl/siso_rx_pkg.sv
// Shared types and helpers for the framed serial receiver.
package siso_rx_pkg;

    localparam int MAX_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    // Returns the even-parity bit for a word (1 when the word has an odd number of ones).
    function automatic logic even_parity(input logic [MAX_DATA_W-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/rx_out_buf.sv
// One-entry valid/ready holding register for received words, with overrun flag.
// Latency: a word offered on in_vld is visible on out_vld/out_dat after one edge.
// Backpressure: never stalls the producer; a word arriving while full and not being drained is dropped and overrun pulses.
module rx_out_buf #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_vld,
    input  logic [W-1:0] in_dat,
    input  logic         in_err,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_dat,
    output logic         out_err,
    output logic         overrun
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_vld <= 1'b0;
            out_dat <= '0;
            out_err <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (in_vld && (!out_vld || out_rdy)) begin
                out_vld <= 1'b1;
                out_dat <= in_dat;
                out_err <= in_err;
            end else if (in_vld) begin
                // Full and not draining: the held word wins, the new one is lost.
                overrun <= 1'b1;
            end else if (out_vld && out_rdy) begin
                out_vld <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/siso_frame_rx.sv
// Framed serial receiver: start bit, DATA_W bits LSB first, optional even parity, stop bit.
// Latency: data_valid rises on the edge that samples a good stop bit (edge 2+DATA_W+PARITY_EN).
// Backpressure: one-entry output buffer; words completing while it is full are dropped with an overrun pulse.
module siso_frame_rx #(
    parameter int DATA_W    = 4,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              serial_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun
);

    import siso_rx_pkg::*;

    localparam int CNT_W = $clog2(DATA_W + 1);

    rx_state_t         state;
    rx_state_t         state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_nxt;
    logic              par_acc;
    logic              last_bit;
    logic              stop_ok;
    logic              stop_bad;

    // Right shift with the new bit entering at the MSB, so the first bit ends in bit 0.
    assign shreg_nxt = (shreg >> 1) | (DATA_W'(serial_in) << (DATA_W - 1));
    assign last_bit  = (cnt == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        stop_ok   = 1'b0;
        stop_bad  = 1'b0;
        case (state)
            IDLE: begin
                if (serial_in) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (last_bit) begin
                    state_nxt = PARITY_EN ? PARITY : STOP;
                end
            end
            PARITY: begin
                state_nxt = STOP;
            end
            STOP: begin
                // A high stop bit is an error, not the start of the next frame.
                state_nxt = IDLE;
                stop_ok   = ~serial_in;
                stop_bad  = serial_in;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt       <= '0;
            shreg     <= '0;
            par_acc   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            case (state)
                IDLE: begin
                    if (serial_in) begin
                        cnt     <= '0;
                        par_acc <= 1'b0;
                    end
                end
                DATA: begin
                    shreg   <= shreg_nxt;
                    cnt     <= cnt + CNT_W'(1);
                    par_acc <= par_acc ^ serial_in;
                end
                PARITY: begin
                    par_acc <= par_acc ^ serial_in;
                end
                default: begin
                end
            endcase
        end
    end

    rx_out_buf #(
        .W (DATA_W)
    ) u_out_buf (
        .clk     (clk),
        .reset   (reset),
        .in_vld  (stop_ok),
        .in_dat  (shreg),
        .in_err  (par_acc & PARITY_EN),
        .out_vld (data_valid),
        .out_rdy (data_ready),
        .out_dat (data_out),
        .out_err (parity_err),
        .overrun (overrun)
    );

endmodule

// File: tb/tb_siso_frame_rx.sv
// Directed bench for siso_frame_rx with DATA_W=4 and even parity enabled.
module tb_siso_frame_rx;

    import siso_rx_pkg::*;

    logic       clk;
    logic       reset;
    logic       serial_in;
    logic [3:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;

    int vectors     = 0;
    int miscompares = 0;

    siso_frame_rx #(
        .DATA_W    (4),
        .PARITY_EN (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .serial_in  (serial_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one line bit, let the DUT sample it, then settle just past the edge.
    task automatic send_bit(input logic b);
        serial_in = b;
        @(posedge clk);
        #1;
    endtask

    // Start bit, four data bits LSB first, then the parity bit; the caller sends the stop bit.
    task automatic send_body(input logic [3:0] d, input logic par);
        send_bit(1'b1);
        for (int i = 0; i < 4; i++) begin
            send_bit(d[i]);
        end
        send_bit(par);
    endtask

    initial begin
        reset      = 1'b0;
        serial_in  = 1'b0;
        data_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_data_out",   32'(data_out),   32'h0);
        check("rst_data_valid", 32'(data_valid), 32'h0);
        check("rst_parity_err", 32'(parity_err), 32'h0);
        check("rst_frame_err",  32'(frame_err),  32'h0);
        check("rst_overrun",    32'(overrun),    32'h0);
        check("rst_state",      32'(dut.state),  32'(IDLE));

        reset = 1'b1;
        send_bit(1'b0);

        // Good frame 4'hB with parity 1; valid must appear exactly at edge 7.
        data_ready = 1'b1;
        send_body(4'hB, 1'b1);
        check("good_valid_early", 32'(data_valid), 32'h0);
        send_bit(1'b0);
        check("good_valid",      32'(data_valid), 32'h1);
        check("good_data",       32'(data_out),   32'hB);
        check("good_parity_err", 32'(parity_err), 32'h0);
        send_bit(1'b0);
        check("good_accepted",   32'(data_valid), 32'h0);
        check("good_data_hold",  32'(data_out),   32'hB);

        // Same word with the parity bit wrong: still delivered, flagged.
        data_ready = 1'b0;
        send_body(4'hB, 1'b0);
        send_bit(1'b0);
        check("perr_valid",     32'(data_valid), 32'h1);
        check("perr_data",      32'(data_out),   32'hB);
        check("perr_flag",      32'(parity_err), 32'h1);
        check("perr_frame_err", 32'(frame_err),  32'h0);
        data_ready = 1'b1;
        send_bit(1'b0);
        check("perr_accepted",  32'(data_valid), 32'h0);
        data_ready = 1'b0;

        // Stop bit 1: framing error, word discarded, receiver back in IDLE.
        send_body(4'hB, 1'b1);
        send_bit(1'b1);
        check("ferr_pulse", 32'(frame_err),  32'h1);
        check("ferr_valid", 32'(data_valid), 32'h0);
        check("ferr_state", 32'(dut.state),  32'(IDLE));
        send_bit(1'b0);
        check("ferr_pulse_end", 32'(frame_err),  32'h0);
        check("ferr_idle_hold", 32'(dut.state),  32'(IDLE));
        check("ferr_no_word",   32'(data_valid), 32'h0);

        // Overrun: 4'h3 held, back-to-back 4'h5 dropped.
        send_body(4'h3, 1'b0);
        send_bit(1'b0);
        check("ovr_first_valid", 32'(data_valid), 32'h1);
        check("ovr_first_data",  32'(data_out),   32'h3);
        send_body(4'h5, 1'b0);
        send_bit(1'b0);
        check("ovr_pulse",     32'(overrun),    32'h1);
        check("ovr_data_kept", 32'(data_out),   32'h3);
        check("ovr_valid",     32'(data_valid), 32'h1);
        data_ready = 1'b1;
        send_bit(1'b0);
        check("ovr_pulse_end", 32'(overrun),    32'h0);
        check("ovr_accepted",  32'(data_valid), 32'h0);
        check("ovr_data_hold", 32'(data_out),   32'h3);
        data_ready = 1'b0;

        // Accept of the held word coincides with the next completion.
        send_body(4'h3, 1'b0);
        send_bit(1'b0);
        check("sim_first_data", 32'(data_out), 32'h3);
        send_body(4'h5, 1'b0);
        data_ready = 1'b1;
        send_bit(1'b0);
        check("sim_valid",      32'(data_valid), 32'h1);
        check("sim_data",       32'(data_out),   32'h5);
        check("sim_no_overrun", 32'(overrun),    32'h0);
        data_ready = 1'b0;
        send_bit(1'b0);
        check("sim_hold_valid", 32'(data_valid), 32'h1);
        check("sim_hold_data",  32'(data_out),   32'h5);

        // Reset after three data bits, with 4'h5 still buffered.
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        reset = 1'b0;
        send_bit(1'b0);
        check("mrst_data_out",   32'(data_out),   32'h0);
        check("mrst_data_valid", 32'(data_valid), 32'h0);
        check("mrst_parity_err", 32'(parity_err), 32'h0);
        check("mrst_frame_err",  32'(frame_err),  32'h0);
        check("mrst_overrun",    32'(overrun),    32'h0);
        reset = 1'b1;
        send_bit(1'b0);
        send_body(4'hA, 1'b0);
        send_bit(1'b0);
        check("mrst_new_valid",  32'(data_valid), 32'h1);
        check("mrst_new_data",   32'(data_out),   32'hA);
        check("mrst_new_perr",   32'(parity_err), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/siso_frame_rx.md
# siso_frame_rx

Downstream consumer of the 4-bit SISO shift register's `serial_out` stream. It recognises framed serial words (start bit, DATA_W data bits LSB first, optional even parity, stop bit), converts them to parallel form, and offers each word through a one-entry valid/ready output buffer. It also flags parity errors, framing errors and overruns.

## Interface
- `DATA_W`, default 4: data bits per frame (legal range 1–16).
- `PARITY_EN`, default 1: 1 means a parity bit follows the data; 0 means no parity bit.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `reset`  in  1: synchronous, active-low reset.
- `serial_in`  in  1: serial line, driven by the SISO `serial_out`. Idle level is 0.
- `data_out`  out  DATA_W: received word; first bit received lands in `data_out[0]`.
- `data_valid`  out  1: a word is held in the buffer.
- `data_ready`  in  1: consumer accepts the word when `data_valid && data_ready`.
- `parity_err`  out  1: parity result for the word in `data_out`; valid only while `data_valid` is high.
- `frame_err`  out  1: one-cycle pulse when the stop bit is 1.
- `overrun`  out  1: one-cycle pulse when a completed word is dropped because the buffer is full.

## Operation
- Reset (`reset`=0 at a clock edge):
  - State goes to IDLE.
  - `data_out`=0, `data_valid`=0, `parity_err`=0, `frame_err`=0, `overrun`=0.
  - The bit counter and shift register are cleared.
  - Reset mid-frame discards the partial frame. Reset with a word in the buffer discards that word.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: if `serial_in`=1 is sampled, go to DATA (this is the start bit) and clear the bit counter. If 0 is sampled, stay in IDLE.
  - DATA: shift `serial_in` into the MSB of the shift register (right shift) and increment the counter. After DATA_W bits, go to PARITY if `PARITY_EN`=1, otherwise go to STOP.
  - PARITY: sample the parity bit. Even parity applies: XOR of the data bits and the parity bit must be 0. Go to STOP.
  - STOP: sample the stop bit and always return to IDLE.
    - Stop bit 0: the frame completes (see buffer rules below).
    - Stop bit 1: framing error. Discard the word, pulse `frame_err`, and do not treat that 1 as a new start bit.
- Output buffer rules, evaluated at the completing edge:
  - Buffer empty, or `data_valid && data_ready` in the same cycle: load `data_out` and `parity_err`; `data_valid` is 1 after the edge.
  - Buffer full and `data_ready`=0: keep the old word, drop the new word, pulse `overrun`.
  - `data_valid && data_ready` with no completion: `data_valid` becomes 0. `data_out` holds its value.
- A parity error does not block delivery. The word is delivered with `parity_err`=1.

## Timing
- Frame length is F = 2 + DATA_W + PARITY_EN cycles. Default F = 7.
- Back-to-back frames are allowed: a start bit may be sampled on the cycle right after STOP.
- Latency: `data_valid` rises on the same edge that samples a good stop bit. That is edge F, counting the start-bit edge as edge 1.
- The pulse outputs `frame_err` and `overrun` are high for exactly the one cycle after the STOP edge.
- `data_out` and `parity_err` are stable while `data_valid`=1 and not yet accepted.
- All outputs are registered. There are no combinational paths from input to output.

## Structure
- Package `siso_rx_pkg` holds:
  - the state enum `rx_state_t` (IDLE, DATA, PARITY, STOP);
  - the function `even_parity(word)`.
- Sub-module `rx_out_buf`: the one-entry valid/ready holding register with overrun detection, parameterised by width.
- Top level holds the FSM, bit counter (`$clog2(DATA_W+1)` bits), shift register and parity accumulator.

## Test plan
All scenarios use DATA_W=4, PARITY_EN=1 unless noted; bits are listed in time order.
- **Good frame.** Hold `data_ready`=1 and send 1,1,1,0,1,1,0 (start; data 1101 LSB-first; parity 1; stop). Expect `data_out`=4'hB, `parity_err`=0, and `data_valid` high at edge 7.
- **Parity error.** Send the same frame with parity 0. Expect `data_out`=4'hB, `parity_err`=1, `data_valid`=1, `frame_err`=0.
- **Framing error.** Send stop bit 1. Expect a `frame_err` pulse, `data_valid` stays 0, and the FSM is in IDLE, with the next 0 keeping it there.
- **Overrun.** Hold `data_ready`=0 and send 4'h3 then 4'h5. Expect `data_out` to stay 4'h3 and `overrun` to pulse at the second STOP edge. Then raise `data_ready`: 4'h3 is accepted and `data_valid` goes to 0.
- **Simultaneous accept and complete.** Raise `data_ready` on the STOP edge of the second frame. Expect `data_valid` to stay 1 with the new word and no `overrun`.
- **Reset mid-frame.** Assert `reset`=0 after 3 data bits, then send a full frame 4'hA. Expect all outputs 0 during reset, then `data_out`=4'hA with no residue from the aborted frame.
